// File: rtl/ball_if.sv
// Ball controller signal bundle: frame/pixel-pipeline inputs and ball state outputs.
// master = pixel pipeline / frame timing side, slave = ball_controller.
interface ball_if;
  logic       frame_start;
  logic       serve;
  logic [9:0] paddle_x;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       in_ball;
  logic       in_brick;
  logic       in_paddle;
  logic [9:0] x;
  logic [8:0] y;
  logic       ball_active;
  logic       brick_hit;
  logic       lost;

  modport master (
    output frame_start, serve, paddle_x, hpos, vpos, in_ball, in_brick, in_paddle,
    input  x, y, ball_active, brick_hit, lost
  );

  modport slave (
    input  frame_start, serve, paddle_x, hpos, vpos, in_ball, in_brick, in_paddle,
    output x, y, ball_active, brick_hit, lost
  );
endinterface

// File: rtl/ball_controller.sv
// Breakout ball motion sequencer: holds the ball on the paddle until served,
// gathers overlap evidence during the frame and moves/reflects it once per frame.
// Optional macro BALL_SPEEDUP_EN: every 8th paddle-touching frame raises the
// step size by one pixel (max 4); the step returns to BALL_SPEED on SERVE entry.
//
// state    | meaning
// S_SERVE  | ball parked on the paddle, follows paddle_x
// S_PLAY   | ball moving, collision evidence being collected
// S_UPDATE | single cycle: reflect, step, detect loss
// S_LOST   | ball out of play, waiting for serve
module ball_controller #(
  parameter int BALL_WIDTH = 5,
  parameter int BALL_SPEED = 2,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int PADDLE_TOP = 456
) (
  input logic   clk,
  input logic   reset,
  ball_if.slave bus
);
  localparam int HALF = BALL_WIDTH / 2;
  localparam logic signed [10:0] HALF_S  = 11'(HALF);
  localparam logic signed [10:0] XMAX_S  = 11'(SCREEN_W - 1 - HALF);
  localparam logic signed [10:0] YLOST_S = 11'(SCREEN_H - 1 + HALF);
  localparam logic [8:0]         Y_SERVE = 9'(PADDLE_TOP - HALF - 1);
  localparam logic [9:0]         X_RESET = 10'(SCREEN_W / 2);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_UPDATE, S_LOST} state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       dir_right_q, dir_right_d, dir_down_q, dir_down_d;
  logic       active_q, active_d, brick_hit_q, brick_hit_d, lost_q, lost_d;
  logic       hit_l_q, hit_l_d, hit_r_q, hit_r_d, hit_t_q, hit_t_d, hit_b_q, hit_b_d;
  logic       brick_seen_q, brick_seen_d;
  logic       hit_evt, dx, dy;
  logic [2:0] speed;
  logic signed [10:0] sx, sy, px, spd, nx, ny;

  assign hit_evt = bus.in_ball && (bus.in_brick || bus.in_paddle);
  assign sx  = {1'b0, x_q};
  assign sy  = {2'b0, y_q};
  assign px  = {1'b0, bus.paddle_x};
  assign spd = {8'b0, speed};

  // Next-state, motion arithmetic and sticky collision flags.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_right_d  = dir_right_q;
    dir_down_d   = dir_down_q;
    active_d     = active_q;
    brick_hit_d  = 1'b0;
    lost_d       = 1'b0;
    hit_l_d      = hit_l_q;
    hit_r_d      = hit_r_q;
    hit_t_d      = hit_t_q;
    hit_b_d      = hit_b_q;
    brick_seen_d = brick_seen_q;
    dx           = dir_right_q;
    dy           = dir_down_q;
    nx           = sx;
    ny           = sy;
    case (state_q)
      S_SERVE: begin
        active_d = 1'b1;
        y_d      = Y_SERVE;
        if (px < HALF_S)      x_d = 10'(HALF_S);
        else if (px > XMAX_S) x_d = 10'(XMAX_S);
        else                  x_d = bus.paddle_x;
        if (bus.frame_start && bus.serve) begin
          dir_right_d  = 1'b1;
          dir_down_d   = 1'b0;
          hit_l_d      = 1'b0;
          hit_r_d      = 1'b0;
          hit_t_d      = 1'b0;
          hit_b_d      = 1'b0;
          brick_seen_d = 1'b0;
          state_d      = S_PLAY;
        end
      end
      S_PLAY: begin
        // A collision on the frame_start cycle still counts for this frame.
        if (hit_evt) begin
          if ({1'b0, bus.hpos} < sx) hit_l_d = 1'b1;
          if ({1'b0, bus.hpos} > sx) hit_r_d = 1'b1;
          if ({2'b0, bus.vpos} < sy) hit_t_d = 1'b1;
          if ({2'b0, bus.vpos} > sy) hit_b_d = 1'b1;
          if (bus.in_brick) brick_seen_d = 1'b1;
        end
        if (bus.frame_start) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (hit_l_q && !hit_r_q)      dx = 1'b1;
        else if (hit_r_q && !hit_l_q) dx = 1'b0;
        else if (hit_l_q && hit_r_q)  dx = !dir_right_q;
        if (hit_t_q && !hit_b_q)      dy = 1'b1;
        else if (hit_b_q && !hit_t_q) dy = 1'b0;
        else if (hit_t_q && hit_b_q)  dy = !dir_down_q;
        // Walls override object reflection; there is no bottom wall.
        if (!dx && (sx - spd) < HALF_S)     dx = 1'b1;
        else if (dx && (sx + spd) > XMAX_S) dx = 1'b0;
        if (!dy && (sy - spd) < HALF_S)     dy = 1'b1;
        nx = dx ? sx + spd : sx - spd;
        if (nx < HALF_S)      nx = HALF_S;
        else if (nx > XMAX_S) nx = XMAX_S;
        ny = dy ? sy + spd : sy - spd;
        if (ny < HALF_S) ny = HALF_S;
        x_d          = nx[9:0];
        y_d          = ny[8:0];
        dir_right_d  = dx;
        dir_down_d   = dy;
        brick_hit_d  = brick_seen_q;
        hit_l_d      = 1'b0;
        hit_r_d      = 1'b0;
        hit_t_d      = 1'b0;
        hit_b_d      = 1'b0;
        brick_seen_d = 1'b0;
        if (ny > YLOST_S) begin
          lost_d   = 1'b1;
          active_d = 1'b0;
          state_d  = S_LOST;
        end else begin
          state_d  = S_PLAY;
        end
      end
      S_LOST: begin
        active_d = 1'b0;
        if (bus.frame_start && bus.serve) begin
          active_d = 1'b1;
          state_d  = S_SERVE;
        end
      end
      default: state_d = S_SERVE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SERVE;
      x_q          <= X_RESET;
      y_q          <= Y_SERVE;
      dir_right_q  <= 1'b1;
      dir_down_q   <= 1'b0;
      active_q     <= 1'b1;
      brick_hit_q  <= 1'b0;
      lost_q       <= 1'b0;
      hit_l_q      <= 1'b0;
      hit_r_q      <= 1'b0;
      hit_t_q      <= 1'b0;
      hit_b_q      <= 1'b0;
      brick_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_right_q  <= dir_right_d;
      dir_down_q   <= dir_down_d;
      active_q     <= active_d;
      brick_hit_q  <= brick_hit_d;
      lost_q       <= lost_d;
      hit_l_q      <= hit_l_d;
      hit_r_q      <= hit_r_d;
      hit_t_q      <= hit_t_d;
      hit_b_q      <= hit_b_d;
      brick_seen_q <= brick_seen_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic       paddle_seen_q, paddle_seen_d;
  logic [2:0] hits_q, hits_d, speed_q, speed_d;

  // Count paddle-touching frames; each wrap of the counter adds a pixel of speed.
  always_comb begin
    paddle_seen_d = paddle_seen_q;
    hits_d        = hits_q;
    speed_d       = speed_q;
    if (state_q == S_PLAY && bus.in_ball && bus.in_paddle) paddle_seen_d = 1'b1;
    if (state_q == S_UPDATE) begin
      paddle_seen_d = 1'b0;
      if (paddle_seen_q) begin
        hits_d = hits_q + 3'd1;
        if (hits_q == 3'd7 && speed_q < 3'd4) speed_d = speed_q + 3'd1;
      end
    end
    if (state_q == S_SERVE && state_d == S_PLAY) paddle_seen_d = 1'b0;
    if (state_q != S_SERVE && state_d == S_SERVE) begin
      hits_d  = 3'd0;
      speed_d = 3'(BALL_SPEED);
    end
  end

  // Speed-up bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      paddle_seen_q <= 1'b0;
      hits_q        <= 3'd0;
      speed_q       <= 3'(BALL_SPEED);
    end else begin
      paddle_seen_q <= paddle_seen_d;
      hits_q        <= hits_d;
      speed_q       <= speed_d;
    end
  end

  assign speed = speed_q;
`else
  assign speed = 3'(BALL_SPEED);
`endif

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.ball_active = active_q;
  assign bus.brick_hit   = brick_hit_q;
  assign bus.lost        = lost_q;
endmodule
